// File: rtl/vocab_matcher_lat_if.sv
// Handshake/bus bundle between the vocabulary matcher, its two sync RAMs and
// the tokenizer control FSM. The master side owns start, the lookup window and
// the RAM read data. The slave side (the matcher) owns addresses and results.
interface vocab_matcher_lat_if #(
  parameter int ADDR_WIDTH       = 4,
  parameter int VOCAB_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int TOK_IDX_WIDTH    = 4
);
  logic                        start;
  logic [VOCAB_ADDR_WIDTH-1:0] vocab_start_addr;
  logic [VOCAB_ADDR_WIDTH-1:0] vocab_end_addr;
  logic [ADDR_WIDTH-1:0]       input_start_addr;
  logic [DATA_WIDTH-1:0]       val_vocab;
  logic [DATA_WIDTH-1:0]       val_input;
  logic [VOCAB_ADDR_WIDTH-1:0] addr_v;
  logic [ADDR_WIDTH-1:0]       addr_i;
  logic                        busy;
  logic                        done;
  logic                        found;
  logic                        err;
  logic [TOK_IDX_WIDTH-1:0]    token_idx;
  logic [VOCAB_ADDR_WIDTH-1:0] match_addr;

  modport master (
    output start, vocab_start_addr, vocab_end_addr, input_start_addr, val_vocab, val_input,
    input  addr_v, addr_i, busy, done, found, err, token_idx, match_addr
  );

  modport slave (
    input  start, vocab_start_addr, vocab_end_addr, input_start_addr, val_vocab, val_input,
    output addr_v, addr_i, busy, done, found, err, token_idx, match_addr
  );
endinterface

// File: rtl/vocab_matcher_lat.sv
// Vocabulary matcher with configurable RAM read latency.
// Walks a vocabulary of TERM-terminated tokens and compares each one against a
// TERM-terminated input string. It reports the match, the index of the token and
// the token address. An input that runs past MAX_IN_LEN without TERM is an error.
// Each RAM step costs RD_LAT wait cycles plus one decision cycle.
module vocab_matcher_lat #(
  parameter int ADDR_WIDTH       = 4,
  parameter int VOCAB_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int RD_LAT           = 1,
  parameter int TERM             = 0,
  parameter int PREFIX_MODE      = 0,
  parameter int MAX_IN_LEN       = 15,
  parameter int TOK_IDX_WIDTH    = 4
) (
  input logic                clk,
  input logic                rst,
  vocab_matcher_lat_if.slave bus
);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0]         LAT_LAST  = LW'(RD_LAT - 1);
  localparam logic [DATA_WIDTH-1:0] TERM_C    = DATA_WIDTH'(TERM);
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN_C = ADDR_WIDTH'(MAX_IN_LEN);
  localparam bit                    PREFIX    = (PREFIX_MODE != 0);

  typedef enum logic [2:0] {IDLE, WAIT, CMP, SKIP_WAIT, SKIP, DONE} state_t;

  state_t                      state_reg;
  logic [LW-1:0]               lat_cnt_reg;
  logic [VOCAB_ADDR_WIDTH-1:0] tok_base_reg;
  logic [VOCAB_ADDR_WIDTH-1:0] vocab_end_reg;
  logic [ADDR_WIDTH-1:0]       input_start_reg;
  logic [ADDR_WIDTH-1:0]       char_cnt_reg;
  logic [TOK_IDX_WIDTH-1:0]    tok_cnt_reg;

  logic at_end;
  logic in_term;
  logic v_term;
  logic chars_eq;

  // Decode of the current RAM data and the vocab window position.
  always_comb begin
    at_end   = (bus.addr_v == vocab_end_reg);
    in_term  = (bus.val_input == TERM_C);
    v_term   = (bus.val_vocab == TERM_C);
    chars_eq = (bus.val_vocab == bus.val_input);
  end

  // Lookup state machine. Every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      lat_cnt_reg     <= '0;
      tok_base_reg    <= '0;
      vocab_end_reg   <= '0;
      input_start_reg <= '0;
      char_cnt_reg    <= '0;
      tok_cnt_reg     <= '0;
      bus.addr_v      <= '0;
      bus.addr_i      <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.found       <= 1'b0;
      bus.err         <= 1'b0;
      bus.token_idx   <= '0;
      bus.match_addr  <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            vocab_end_reg   <= bus.vocab_end_addr;
            input_start_reg <= bus.input_start_addr;
            bus.addr_v      <= bus.vocab_start_addr;
            bus.addr_i      <= bus.input_start_addr;
            tok_base_reg    <= bus.vocab_start_addr;
            tok_cnt_reg     <= '0;
            char_cnt_reg    <= '0;
            lat_cnt_reg     <= '0;
            bus.done        <= 1'b0;
            bus.found       <= 1'b0;
            bus.err         <= 1'b0;
            bus.token_idx   <= '0;
            bus.match_addr  <= '0;
            bus.busy        <= 1'b1;
            state_reg       <= WAIT;
          end
        end
        WAIT, SKIP_WAIT: begin
          // Let RAM data for the freshly issued address settle.
          if (lat_cnt_reg == LAT_LAST) begin
            lat_cnt_reg <= '0;
            state_reg   <= (state_reg == WAIT) ? CMP : SKIP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LW'(1);
          end
        end
        CMP: begin
          if (at_end) begin
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state_reg <= DONE;
          end else if (char_cnt_reg == MAX_LEN_C && !in_term) begin
            bus.err   <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state_reg <= DONE;
          end else if (in_term && (v_term || PREFIX)) begin
            bus.found      <= 1'b1;
            bus.token_idx  <= tok_cnt_reg;
            bus.match_addr <= tok_base_reg;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            state_reg      <= DONE;
          end else if (chars_eq && !in_term) begin
            bus.addr_v   <= bus.addr_v + VOCAB_ADDR_WIDTH'(1);
            bus.addr_i   <= bus.addr_i + ADDR_WIDTH'(1);
            char_cnt_reg <= char_cnt_reg + ADDR_WIDTH'(1);
            state_reg    <= WAIT;
          end else if (v_term) begin
            // Token ended before the input did: rewind input, next token.
            tok_base_reg <= bus.addr_v + VOCAB_ADDR_WIDTH'(1);
            bus.addr_v   <= bus.addr_v + VOCAB_ADDR_WIDTH'(1);
            tok_cnt_reg  <= tok_cnt_reg + TOK_IDX_WIDTH'(1);
            bus.addr_i   <= input_start_reg;
            char_cnt_reg <= '0;
            state_reg    <= WAIT;
          end else begin
            bus.addr_v <= bus.addr_v + VOCAB_ADDR_WIDTH'(1);
            state_reg  <= SKIP_WAIT;
          end
        end
        SKIP: begin
          if (at_end) begin
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state_reg <= DONE;
          end else if (v_term) begin
            tok_base_reg <= bus.addr_v + VOCAB_ADDR_WIDTH'(1);
            bus.addr_v   <= bus.addr_v + VOCAB_ADDR_WIDTH'(1);
            tok_cnt_reg  <= tok_cnt_reg + TOK_IDX_WIDTH'(1);
            bus.addr_i   <= input_start_reg;
            char_cnt_reg <= '0;
            state_reg    <= WAIT;
          end else begin
            bus.addr_v <= bus.addr_v + VOCAB_ADDR_WIDTH'(1);
            state_reg  <= SKIP_WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vocab_matcher_lat.sv
// Bench for vocab_matcher_lat. Four matcher instances share one vocab image and
// one input image:
//   0 = base configuration
//   1 = prefix mode
//   2 = MAX_IN_LEN=3
//   3 = RD_LAT=3
// Expected results are queued when a lookup is launched. They are compared
// when the selected instance raises done.
module tb_vocab_matcher_lat;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] vocab_mem [16];
  logic [7:0] input_mem [16];

  logic       start_p   = 1'b0;
  int         start_sel = 0;
  logic [3:0] vs_d      = '0;
  logic [3:0] ve_d      = '0;
  logic [3:0] is_d      = '0;

  logic [N-1:0]       busy_w, done_w, found_w, err_w;
  logic [N-1:0][3:0]  tok_w, maddr_w, av_w, ai_w;

  vocab_matcher_lat_if bus [N] ();

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LAT = (gi == 3) ? 3 : 1;
    logic [7:0] v_pipe [LAT];
    logic [7:0] i_pipe [LAT];

    // Sync RAM model with LAT cycles of read latency.
    always @(posedge clk) begin
      v_pipe[0] <= vocab_mem[bus[gi].addr_v];
      i_pipe[0] <= input_mem[bus[gi].addr_i];
      for (int k = 1; k < LAT; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        i_pipe[k] <= i_pipe[k-1];
      end
    end

    assign bus[gi].val_vocab        = v_pipe[LAT-1];
    assign bus[gi].val_input        = i_pipe[LAT-1];
    assign bus[gi].start            = start_p && (start_sel == gi);
    assign bus[gi].vocab_start_addr = vs_d;
    assign bus[gi].vocab_end_addr   = ve_d;
    assign bus[gi].input_start_addr = is_d;

    assign busy_w[gi]  = bus[gi].busy;
    assign done_w[gi]  = bus[gi].done;
    assign found_w[gi] = bus[gi].found;
    assign err_w[gi]   = bus[gi].err;
    assign tok_w[gi]   = bus[gi].token_idx;
    assign maddr_w[gi] = bus[gi].match_addr;
    assign av_w[gi]    = bus[gi].addr_v;
    assign ai_w[gi]    = bus[gi].addr_i;

    vocab_matcher_lat #(
      .RD_LAT      (LAT),
      .PREFIX_MODE ((gi == 1) ? 1 : 0),
      .MAX_IN_LEN  ((gi == 2) ? 3 : 15)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[gi])
    );
  end

  typedef struct {
    int         dut;
    string      tag;
    logic       found;
    logic       err;
    logic [3:0] tok;
    logic [3:0] maddr;
    int         addr_v;   // -1: not checked
    int         cycles;   // -1: not checked
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_lookup(input string tag, input int d, input logic [3:0] vs, input logic [3:0] ve,
                            input logic [3:0] is, input logic f, input logic e, input logic [3:0] t,
                            input logic [3:0] m, input int av, input int cyc, input bit poke);
    exp_t x;
    int   cycles;
    x.dut = d; x.tag = tag; x.found = f; x.err = e; x.tok = t; x.maddr = m;
    x.addr_v = av; x.cycles = cyc;
    exp_q.push_back(x);
    @(negedge clk);
    vs_d = vs; ve_d = ve; is_d = is; start_sel = d; start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    cycles = 0;
    while (!done_w[d] && cycles < 400) begin
      start_p = poke && (cycles == 4);
      if (start_p) is_d = 4'd3;
      @(negedge clk);
      cycles++;
    end
    start_p = 1'b0;
    x = exp_q.pop_front();
    check({x.tag, "_done"},  32'(done_w[x.dut]),  1);
    check({x.tag, "_busy"},  32'(busy_w[x.dut]),  0);
    check({x.tag, "_found"}, 32'(found_w[x.dut]), 32'(x.found));
    check({x.tag, "_err"},   32'(err_w[x.dut]),   32'(x.err));
    check({x.tag, "_tok"},   32'(tok_w[x.dut]),   32'(x.tok));
    check({x.tag, "_maddr"}, 32'(maddr_w[x.dut]), 32'(x.maddr));
    if (x.addr_v >= 0) check({x.tag, "_addr_v"}, 32'(av_w[x.dut]), x.addr_v);
    if (x.cycles >= 0) check({x.tag, "_cycles"}, cycles, x.cycles);
    $display("txn %s dut%0d found=%0d err=%0d tok=%0d maddr=%0d cycles=%0d", x.tag, x.dut,
             found_w[x.dut], err_w[x.dut], tok_w[x.dut], maddr_w[x.dut], cycles);
  endtask

  task automatic check_zero(input string tag, input int d);
    check({tag, "_busy"},  32'(busy_w[d]),  0);
    check({tag, "_done"},  32'(done_w[d]),  0);
    check({tag, "_found"}, 32'(found_w[d]), 0);
    check({tag, "_err"},   32'(err_w[d]),   0);
    check({tag, "_tok"},   32'(tok_w[d]),   0);
    check({tag, "_maddr"}, 32'(maddr_w[d]), 0);
    check({tag, "_addr_v"}, 32'(av_w[d]),   0);
    check({tag, "_addr_i"}, 32'(ai_w[d]),   0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // vocab: "ab\0cd\0" @0, "abcdx\0" @6, "abc\0" @12
    vocab_mem = '{8'h61, 8'h62, 8'h00, 8'h63, 8'h64, 8'h00,
                  8'h61, 8'h62, 8'h63, 8'h64, 8'h78, 8'h00,
                  8'h61, 8'h62, 8'h63, 8'h00};
    // input: "cd\0" @0, "ce\0" @3, "a\0" @6, "abcd" @8, "abc\0" @12
    input_mem = '{8'h63, 8'h64, 8'h00, 8'h63, 8'h65, 8'h00, 8'h61, 8'h00,
                  8'h61, 8'h62, 8'h63, 8'h64, 8'h61, 8'h62, 8'h63, 8'h00};

    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) check_zero($sformatf("reset%0d", d), d);
    rst = 1'b0;

    //          tag           dut vs  ve  is  f  e  tok ma  av  cyc poke
    run_lookup("t1_cd",        0, 0,  6,  0,  1, 0, 1,  3,  -1, 12, 0);
    run_lookup("t2_ce",        0, 0,  6,  3,  0, 0, 0,  0,  6,  14, 0);
    run_lookup("t3_pfx_a",     1, 0,  6,  6,  1, 0, 0,  0,  -1, 4,  0);
    run_lookup("t3_exact_a",   0, 0,  6,  6,  0, 0, 0,  0,  6,  14, 0);
    run_lookup("t4_len_err",   2, 6,  12, 8,  0, 1, 0,  0,  -1, 8,  0);
    run_lookup("len_at_max",   2, 6,  0,  12, 1, 0, 1,  12, -1, 20, 0);
    run_lookup("wrap_err",     2, 6,  0,  8,  0, 1, 0,  0,  -1, 8,  0);
    run_lookup("t5_lat3",      3, 0,  6,  0,  1, 0, 1,  3,  -1, 24, 1);
    run_lookup("empty_vocab",  0, 0,  0,  0,  0, 0, 0,  0,  0,  2,  0);
    run_lookup("truncated",    0, 0,  5,  0,  0, 0, 0,  0,  5,  12, 0);
    run_lookup("empty_token",  0, 2,  6,  5,  1, 0, 0,  2,  -1, 2,  0);
    run_lookup("pfx_empty_in", 1, 0,  6,  7,  1, 0, 0,  0,  -1, 2,  0);

    // Reset in the middle of a lookup aborts it without a done pulse.
    @(negedge clk);
    vs_d = 4'd0; ve_d = 4'd6; is_d = 4'd0; start_sel = 0; start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_busy_mid", 32'(busy_w[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("t6_rst", 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done_w[0]), 0);
    check("t6_idle",    32'(busy_w[0]), 0);
    run_lookup("t6_rerun",     0, 0,  6,  0,  1, 0, 1,  3,  -1, 12, 0);
    run_lookup("t6_from_done", 0, 0,  6,  3,  0, 0, 0,  0,  6,  14, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
